sfq_operand_driver: RTL and testbench
=====================================

// Module: sfq_operand_driver
// PURPOSE
//  Level-to-pulse front end for clocked SFQ gate netlists such as the half adder.
//  Serialises operand word pairs LSB-first onto toggle-encoded pulse lines a_out/b_out/clk_out.
//  Captures the netlist's toggle-encoded s/cout returns and repacks them into result words.
//  Sits between a bus-side testbench/controller (valid/ready) and the SFQ cell netlist.
// PARAMETERS
//  WIDTH          8  operand/result word width, bits (1..32)
//  SLOT_CYCLES    8  system clocks per bit slot (>=4; >=6 when SFQ_DRV_SYNC_EN)
//  CLK_OFS        2  cycle within slot where clk_out toggles (1..SLOT_CYCLES-2)
//  RES_LAT_SLOTS  0  netlist pipeline depth in slots; result of bit k expected in slot k+RES_LAT_SLOTS (0..3)
// PORTS
//  clk       in   1      system clock
//  rst       in   1      synchronous reset, active high
//  op_valid  in   1      operand pair offered
//  op_ready  out  1      driver accepts operand pair
//  op_a      in   WIDTH  operand A
//  op_b      in   WIDTH  operand B
//  a_out     out  1      pulse line A (each toggle = one SFQ pulse)
//  b_out     out  1      pulse line B
//  clk_out   out  1      pulse clock line to netlist
//  s_in      in   1      returned sum pulse line (toggle-encoded)
//  cout_in   in   1      returned carry pulse line
//  res_valid out  1      result word held
//  res_ready in   1      consumer takes result
//  res_s     out  WIDTH  captured sum bits
//  res_cout  out  WIDTH  captured carry bits
//  busy      out  1      high in DRIVE
//  err_stray out  1      sticky: return edge outside capture window or >1 edge in one window
// BEHAVIOUR
//  - Reset: all outputs 0 incl. a_out/b_out/clk_out, res_s/res_cout, err_stray; FSM->IDLE; edge
//    detectors load current s_in/cout_in (no false edge). Reset mid-operation aborts instantly.
//  - FSM: IDLE -(op_valid&op_ready)-> DRIVE -(last slot, last cycle)-> DONE -(res_valid&res_ready)-> IDLE.
//  - op_ready = (state==IDLE); operands latched on handshake; op_ready high again the cycle after
//    a DONE->IDLE transfer.
//  - DRIVE: N = WIDTH+RES_LAT_SLOTS slots, slot counter + cycle counter (0..SLOT_CYCLES-1).
//    cycle 0 of slot j<WIDTH: toggle a_out iff op_a[j], b_out iff op_b[j]; slots >=WIDTH: no data.
//    cycle CLK_OFS of every slot: toggle clk_out (N toggles per operation).
//  - Capture: edge = s_in != s_prev (likewise cout). Window = cycles CLK_OFS+1..SLOT_CYCLES-1.
//    Edge in window of slot j>=RES_LAT_SLOTS sets bit j-RES_LAT_SLOTS; slots <RES_LAT_SLOTS discarded.
//    Edge outside window, or 2nd edge in same window/line: err_stray<=1, bit unaffected.
//  - Latency: handshake in cycle t -> slot 0 cycle 0 at t+1; res_valid=1 at t+1+N*SLOT_CYCLES.
//  - DONE: res_valid, res_s, res_cout stable until res_ready; res_ready ignored when res_valid=0.
//  - Edges arriving in IDLE/DONE flag err_stray; err_stray cleared only by rst.
// CONFIGURATION
//  SFQ_DRV_SYNC_EN defined: s_in/cout_in pass a 2-flop synchroniser before edge detection;
//    capture window shifts +2 cycles (CLK_OFS+3..SLOT_CYCLES+1, tail spills into next slot's
//    cycles 0..1 or into 2 extra post-DRIVE cycles); res_valid at t+3+N*SLOT_CYCLES.
//  Undefined: inputs sampled directly by edge detector; timing as in BEHAVIOUR.
// TESTING
//  - Loopback half-adder model (edge 1 cycle after clk_out), op_a=0x05 op_b=0x03 -> res_s=0x06,
//    res_cout=0x01, res_valid exactly 65 cycles after handshake, err_stray=0.
//  - op_a=0xFF op_b=0x00 -> 8 a_out toggles at slot cycle 0, 0 b_out toggles, 8 clk_out toggles
//    spaced 8 cycles, first at t+3.
//  - Backpressure: res_ready=0 for 20 cycles -> res_* stable, op_ready=0; res_ready=1 -> op_ready=1 next cycle.
//  - s_in toggled at slot cycle 0 -> err_stray=1 and stays 1; corresponding res_s bit 0.
//  - rst asserted in slot 3 -> next cycle all outputs 0, FSM IDLE; op_ready=1 after rst drops.
//  - RES_LAT_SLOTS=1, model delays returns one slot, 0xA5/0x0F -> res_s=0xAA, res_cout=0x05,
//    res_valid at t+73; repeat with SFQ_DRV_SYNC_EN, SLOT_CYCLES=8 -> same data, t+75.

Source files
------------

// File: rtl/sfq_operand_driver.sv
// sfq_operand_driver: turns operand word pairs into toggle-encoded pulse trains for a
// clocked SFQ gate netlist. Bits go out LSB first, one bit slot per SLOT_CYCLES clocks.
// The netlist's toggle-encoded s/cout returns are collected back into result words.
// Build option: define SFQ_DRV_SYNC_EN to pass s_in/cout_in through a 2-flop synchroniser.
// With the option, capture timing lags by 2 cycles and two tail cycles follow DRIVE.
//
// state | meaning
// IDLE  | waiting for an operand pair, op_ready high
// DRIVE | emitting data/clock pulses and capturing returns slot by slot
// TAIL  | synchroniser build only: drains the last 2 delayed capture cycles
// DONE  | result word held until res_ready
module sfq_operand_driver #(
  parameter int WIDTH         = 8,
  parameter int SLOT_CYCLES   = 8,
  parameter int CLK_OFS       = 2,
  parameter int RES_LAT_SLOTS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             a_out,
  output logic             b_out,
  output logic             clk_out,
  input  logic             s_in,
  input  logic             cout_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_s,
  output logic [WIDTH-1:0] res_cout,
  output logic             busy,
  output logic             err_stray
);

  localparam int N  = WIDTH + RES_LAT_SLOTS;
  localparam int SW = $clog2(N + 1);
  localparam int CW = $clog2(SLOT_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, TAIL = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_nx;
  logic [SW-1:0]    slot;
  logic [CW-1:0]    cyc;
  logic             last;
  logic             tail_cnt;
  logic             hs;
  logic [WIDTH-1:0] a_sh, b_sh, a_nx, b_nx;

  logic             cap_act;
  logic [SW-1:0]    cap_slot;
  logic [CW-1:0]    cap_cyc;
  logic             s_v, c_v, s_prev, c_prev, seen_s, seen_c;
  logic             edge_s, edge_c, in_win;
  logic [WIDTH-1:0] bit_mask;

  assign last = (slot == SW'(N - 1)) && (cyc == CW'(SLOT_CYCLES - 1));
  assign hs   = (state == IDLE) && op_valid;

  // Status outputs decoded from state; op_ready is held off while reset is asserted.
  always_comb begin
    op_ready  = (state == IDLE) && !rst;
    busy      = (state == DRIVE);
    res_valid = (state == DONE);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (op_valid) state_nx = DRIVE;
      DRIVE: if (last) begin
`ifdef SFQ_DRV_SYNC_EN
        state_nx = TAIL;
`else
        state_nx = DONE;
`endif
      end
      TAIL:  if (tail_cnt) state_nx = DONE;
      DONE:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, tail counter and slot/cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tail_cnt <= 1'b0;
      slot     <= '0;
      cyc      <= '0;
    end else begin
      state    <= state_nx;
      tail_cnt <= (state == TAIL) ? ~tail_cnt : 1'b0;
      if (state == DRIVE) begin
        if (cyc == CW'(SLOT_CYCLES - 1)) begin
          cyc  <= '0;
          slot <= slot + SW'(1);
        end else begin
          cyc <= cyc + CW'(1);
        end
      end else begin
        slot <= '0;
        cyc  <= '0;
      end
    end
  end

  // Data bits queued for the next slot; empty once all WIDTH bits have gone out.
  always_comb begin
    a_nx = a_sh >> 1;
    b_nx = b_sh >> 1;
  end

  // Pulse lines are registered one cycle early so the toggle is visible in the slot cycle it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out   <= 1'b0;
      b_out   <= 1'b0;
      clk_out <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
    end else if (hs) begin
      a_sh  <= op_a;
      b_sh  <= op_b;
      a_out <= a_out ^ op_a[0];
      b_out <= b_out ^ op_b[0];
    end else if (state == DRIVE) begin
      if (cyc == CW'(SLOT_CYCLES - 1)) begin
        a_sh  <= a_nx;
        b_sh  <= b_nx;
        a_out <= a_out ^ a_nx[0];
        b_out <= b_out ^ b_nx[0];
      end
      if (cyc == CW'(CLK_OFS - 1)) clk_out <= ~clk_out;
    end
  end

`ifdef SFQ_DRV_SYNC_EN
  logic          s_m, s_sync, c_m, c_sync, act_d1, act_d2;
  logic [SW-1:0] slot_d1, slot_d2;
  logic [CW-1:0] cyc_d1, cyc_d2;

  // Two-flop synchroniser, with the slot/cycle position delayed to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_m     <= s_in;
      s_sync  <= s_in;
      c_m     <= cout_in;
      c_sync  <= cout_in;
      act_d1  <= 1'b0;
      act_d2  <= 1'b0;
      slot_d1 <= '0;
      slot_d2 <= '0;
      cyc_d1  <= '0;
      cyc_d2  <= '0;
    end else begin
      s_m     <= s_in;
      s_sync  <= s_m;
      c_m     <= cout_in;
      c_sync  <= c_m;
      act_d1  <= (state == DRIVE);
      act_d2  <= act_d1;
      slot_d1 <= slot;
      slot_d2 <= slot_d1;
      cyc_d1  <= cyc;
      cyc_d2  <= cyc_d1;
    end
  end

  assign s_v      = s_sync;
  assign c_v      = c_sync;
  assign cap_act  = act_d2;
  assign cap_slot = slot_d2;
  assign cap_cyc  = cyc_d2;
`else
  assign s_v      = s_in;
  assign c_v      = cout_in;
  assign cap_act  = (state == DRIVE);
  assign cap_slot = slot;
  assign cap_cyc  = cyc;
`endif

  // Edge detection, capture window and target result bit (slots before the latency are discarded).
  always_comb begin
    edge_s   = s_v != s_prev;
    edge_c   = c_v != c_prev;
    in_win   = cap_act && (cap_cyc >= CW'(CLK_OFS + 1));
    bit_mask = '0;
    if (int'(cap_slot) >= RES_LAT_SLOTS)
      bit_mask = WIDTH'(1) << (cap_slot - SW'(RES_LAT_SLOTS));
  end

  // Result capture and sticky stray-edge flag; results clear when a new operand pair is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev    <= s_in;
      c_prev    <= cout_in;
      seen_s    <= 1'b0;
      seen_c    <= 1'b0;
      res_s     <= '0;
      res_cout  <= '0;
      err_stray <= 1'b0;
    end else begin
      s_prev <= s_v;
      c_prev <= c_v;
      seen_s <= in_win && (seen_s || edge_s);
      seen_c <= in_win && (seen_c || edge_c);
      if (edge_s) begin
        if (!in_win || seen_s) err_stray <= 1'b1;
        else res_s <= res_s | bit_mask;
      end
      if (edge_c) begin
        if (!in_win || seen_c) err_stray <= 1'b1;
        else res_cout <= res_cout | bit_mask;
      end
      if (hs) begin
        res_s    <= '0;
        res_cout <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sfq_operand_driver.sv
// Bench for sfq_operand_driver: dut0 uses the default parameters, dut1 has RES_LAT_SLOTS=1.
// Each DUT is looped back through a behavioural SFQ half-adder model.
module tb_sfq_operand_driver;
  localparam int W  = 8;
  localparam int SC = 8;
`ifdef SFQ_DRV_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
    int           lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic         op_valid0 = 1'b0, op_ready0, a_out0, b_out0, clk_out0, s_in0, cout_in0;
  logic         res_valid0, res_ready0 = 1'b0, busy0, err0;
  logic [W-1:0] op_a0 = '0, op_b0 = '0, res_s0, res_cout0;
  logic         op_valid1 = 1'b0, op_ready1, a_out1, b_out1, clk_out1, s_in1, cout_in1;
  logic         res_valid1, res_ready1 = 1'b0, busy1, err1;
  logic [W-1:0] op_a1 = '0, op_b1 = '0, res_s1, res_cout1;

  sfq_operand_driver #(.WIDTH(W), .SLOT_CYCLES(SC), .CLK_OFS(2), .RES_LAT_SLOTS(0)) dut0 (
    .clk(clk), .rst(rst), .op_valid(op_valid0), .op_ready(op_ready0), .op_a(op_a0), .op_b(op_b0),
    .a_out(a_out0), .b_out(b_out0), .clk_out(clk_out0), .s_in(s_in0), .cout_in(cout_in0),
    .res_valid(res_valid0), .res_ready(res_ready0), .res_s(res_s0), .res_cout(res_cout0),
    .busy(busy0), .err_stray(err0));

  sfq_operand_driver #(.WIDTH(W), .SLOT_CYCLES(SC), .CLK_OFS(2), .RES_LAT_SLOTS(1)) dut1 (
    .clk(clk), .rst(rst), .op_valid(op_valid1), .op_ready(op_ready1), .op_a(op_a1), .op_b(op_b1),
    .a_out(a_out1), .b_out(b_out1), .clk_out(clk_out1), .s_in(s_in1), .cout_in(cout_in1),
    .res_valid(res_valid1), .res_ready(res_ready1), .res_s(res_s1), .res_cout(res_cout1),
    .busy(busy1), .err_stray(err1));

  // Half-adder model for dut0: returns toggle one cycle after the clock pulse.
  logic s_mod0 = 1'b0, c_mod0 = 1'b0, s_inj = 1'b0;
  logic ap0 = 1'b0, bp0 = 1'b0, cp0 = 1'b0, pa0 = 1'b0, pb0 = 1'b0;
  logic ha0, hb0;
  assign s_in0    = s_mod0 ^ s_inj;
  assign cout_in0 = c_mod0;
  assign ha0      = pa0 | (a_out0 != ap0);
  assign hb0      = pb0 | (b_out0 != bp0);
  always @(posedge clk) begin
    if (rst) begin
      ap0 <= 1'b0; bp0 <= 1'b0; cp0 <= 1'b0; pa0 <= 1'b0; pb0 <= 1'b0;
    end else begin
      ap0 <= a_out0; bp0 <= b_out0; cp0 <= clk_out0;
      if (clk_out0 != cp0) begin
        if (ha0 ^ hb0) s_mod0 <= ~s_mod0;
        if (ha0 & hb0) c_mod0 <= ~c_mod0;
        pa0 <= 1'b0; pb0 <= 1'b0;
      end else begin
        pa0 <= ha0; pb0 <= hb0;
      end
    end
  end

  // Half-adder model for dut1: same cell, returns delayed by one full slot.
  logic s_mod1 = 1'b0, c_mod1 = 1'b0;
  logic ap1 = 1'b0, bp1 = 1'b0, cp1 = 1'b0, pa1 = 1'b0, pb1 = 1'b0;
  logic ha1, hb1, ck1;
  logic [SC-1:0] ps1 = '0, pc1 = '0;
  assign s_in1    = s_mod1;
  assign cout_in1 = c_mod1;
  assign ha1      = pa1 | (a_out1 != ap1);
  assign hb1      = pb1 | (b_out1 != bp1);
  assign ck1      = clk_out1 != cp1;
  always @(posedge clk) begin
    if (rst) begin
      ap1 <= 1'b0; bp1 <= 1'b0; cp1 <= 1'b0; pa1 <= 1'b0; pb1 <= 1'b0;
      ps1 <= '0; pc1 <= '0;
    end else begin
      ap1 <= a_out1; bp1 <= b_out1; cp1 <= clk_out1;
      if (ps1[SC-1]) s_mod1 <= ~s_mod1;
      if (pc1[SC-1]) c_mod1 <= ~c_mod1;
      ps1 <= {ps1[SC-2:0], ck1 & (ha1 ^ hb1)};
      pc1 <= {pc1[SC-2:0], ck1 & ha1 & hb1};
      pa1 <= ck1 ? 1'b0 : ha1;
      pb1 <= ck1 ? 1'b0 : hb1;
    end
  end

  // Toggle timestamps of dut0 pulse lines.
  int   a_t[$], b_t[$], k_t[$];
  logic am = 1'b0, bm = 1'b0, km = 1'b0;
  always @(negedge clk) begin
    if (a_out0 !== am) a_t.push_back(cyc_cnt);
    if (b_out0 !== bm) b_t.push_back(cyc_cnt);
    if (clk_out0 !== km) k_t.push_back(cyc_cnt);
    am <= a_out0; bm <= b_out0; km <= clk_out0;
  end

  task automatic run_op0(input logic [W-1:0] a, input logic [W-1:0] b, input int inj_n,
                         input int hold, output int hs);
    exp_t e;
    int   n;
    e.s = a ^ b; e.c = a & b; e.lat = 65 + SYNC_EXTRA;
    q0.push_back(e);
    @(negedge clk);
    op_a0 = a; op_b0 = b; op_valid0 = 1'b1; hs = cyc_cnt;
    checks++;
    if (op_ready0 !== 1'b1) begin errors++; $display("FAIL op_ready_idle got %b want 1", op_ready0); end
    @(posedge clk); #1;
    op_valid0 = 1'b0; n = 1;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_drive got %b want 1", busy0); end
    while (res_valid0 !== 1'b1 && n < 300) begin
      if (n == inj_n) s_inj = ~s_inj;
      @(posedge clk); #1;
      n++;
    end
    if (res_valid0 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL res_valid_timeout0 got %b want 1", res_valid0);
      q0.delete();
      return;
    end
    e = q0.pop_front();
    checks++;
    if (n !== e.lat) begin errors++; $display("FAIL latency0 got %0d want %0d", n, e.lat); end
    checks++;
    if (res_s0 !== e.s) begin errors++; $display("FAIL res_s0 got %h want %h", res_s0, e.s); end
    checks++;
    if (res_cout0 !== e.c) begin errors++; $display("FAIL res_cout0 got %h want %h", res_cout0, e.c); end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid0 !== 1'b1 || res_s0 !== e.s || res_cout0 !== e.c || op_ready0 !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d got v=%b s=%h c=%h rdy=%b want v=1 s=%h c=%h rdy=0",
                 i, res_valid0, res_s0, res_cout0, op_ready0, e.s, e.c);
      end
    end
    res_ready0 = 1'b1;
    @(posedge clk); #1;
    res_ready0 = 1'b0;
    checks++;
    if (op_ready0 !== 1'b1 || res_valid0 !== 1'b0) begin
      errors++; $display("FAIL release0 got rdy=%b v=%b want rdy=1 v=0", op_ready0, res_valid0);
    end
  endtask

  task automatic run_op1(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    e.s = a ^ b; e.c = a & b; e.lat = 73 + SYNC_EXTRA;
    q1.push_back(e);
    @(negedge clk);
    op_a1 = a; op_b1 = b; op_valid1 = 1'b1;
    @(posedge clk); #1;
    op_valid1 = 1'b0; n = 1;
    while (res_valid1 !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (res_valid1 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL res_valid_timeout1 got %b want 1", res_valid1);
      q1.delete();
      return;
    end
    e = q1.pop_front();
    checks++;
    if (n !== e.lat) begin errors++; $display("FAIL latency1 got %0d want %0d", n, e.lat); end
    checks++;
    if (res_s1 !== e.s) begin errors++; $display("FAIL res_s1 got %h want %h", res_s1, e.s); end
    checks++;
    if (res_cout1 !== e.c) begin errors++; $display("FAIL res_cout1 got %h want %h", res_cout1, e.c); end
    checks++;
    if (err1 !== 1'b0) begin errors++; $display("FAIL err_stray1 got %b want 0", err1); end
    res_ready1 = 1'b1;
    @(posedge clk); #1;
    res_ready1 = 1'b0;
    checks++;
    if (op_ready1 !== 1'b1) begin errors++; $display("FAIL release1 got %b want 1", op_ready1); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_out0, b_out0, clk_out0, res_valid0, busy0, err0, op_ready0, res_s0, res_cout0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs0 got a=%b b=%b k=%b v=%b busy=%b err=%b rdy=%b s=%h c=%h want all 0",
               a_out0, b_out0, clk_out0, res_valid0, busy0, err0, op_ready0, res_s0, res_cout0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (op_ready0 !== 1'b1 || op_ready1 !== 1'b1 || res_valid0 !== 1'b0) begin
      errors++; $display("FAIL reset_release got rdy0=%b rdy1=%b v0=%b want 1 1 0", op_ready0, op_ready1, res_valid0);
    end
  endtask

  task automatic test_add();
    int hs;
    run_op0(8'h05, 8'h03, 0, 0, hs);
    checks++;
    if (err0 !== 1'b0) begin errors++; $display("FAIL add_err_stray got %b want 0", err0); end
  endtask

  task automatic test_pulses();
    int hs, a0, b0, k0, bad;
    a0 = a_t.size(); b0 = b_t.size(); k0 = k_t.size();
    run_op0(8'hFF, 8'h00, 0, 0, hs);
    checks++;
    if (a_t.size() - a0 != 8) begin errors++; $display("FAIL a_toggles got %0d want 8", a_t.size() - a0); end
    bad = 0;
    for (int i = a0; i < a_t.size(); i++) if ((a_t[i] - (hs + 1)) % SC != 0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL a_phase got %0d off-phase want 0", bad); end
    checks++;
    if (b_t.size() - b0 != 0) begin errors++; $display("FAIL b_toggles got %0d want 0", b_t.size() - b0); end
    checks++;
    if (k_t.size() - k0 != 8) begin
      errors++; $display("FAIL clk_toggles got %0d want 8", k_t.size() - k0);
    end else begin
      checks++;
      if (k_t[k0] != hs + 3) begin errors++; $display("FAIL clk_first got %0d want %0d", k_t[k0], hs + 3); end
      bad = 0;
      for (int i = k0 + 1; i < k0 + 8; i++) if (k_t[i] - k_t[i-1] != SC) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL clk_spacing got %0d bad gaps want 0", bad); end
    end
  endtask

  task automatic test_backpressure();
    int hs;
    run_op0(8'h3C, 8'h5A, 0, 20, hs);
    checks++;
    if (err0 !== 1'b0) begin errors++; $display("FAIL bp_err_stray got %b want 0", err0); end
  endtask

  task automatic test_stray();
    int hs;
    run_op0(8'h05, 8'h03, 33, 0, hs);
    checks++;
    if (err0 !== 1'b1) begin errors++; $display("FAIL stray_set got %b want 1", err0); end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (err0 !== 1'b1) begin errors++; $display("FAIL stray_sticky got %b want 1", err0); end
  endtask

  task automatic test_reset_mid();
    int hs;
    @(negedge clk);
    op_a0 = 8'hFF; op_b0 = 8'hFF; op_valid0 = 1'b1;
    @(posedge clk); #1;
    op_valid0 = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy0); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_out0, b_out0, clk_out0, res_valid0, busy0, err0, op_ready0, res_s0, res_cout0} !== '0) begin
      errors++;
      $display("FAIL mid_reset got a=%b b=%b k=%b v=%b busy=%b err=%b rdy=%b s=%h c=%h want all 0",
               a_out0, b_out0, clk_out0, res_valid0, busy0, err0, op_ready0, res_s0, res_cout0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (op_ready0 !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", op_ready0); end
    run_op0(8'h05, 8'h03, 0, 0, hs);
    checks++;
    if (err0 !== 1'b0) begin errors++; $display("FAIL post_reset_err got %b want 0", err0); end
  endtask

  task automatic test_res_latency();
    run_op1(8'hA5, 8'h0F);
  endtask

  initial begin
    test_reset();
    test_add();
    test_pulses();
    test_backpressure();
    test_stray();
    test_reset_mid();
    test_res_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
